// File: rtl/reg_write_arbiter.sv
// Write-back arbiter: merges single-cycle ALU results and FIFO-buffered load
// results onto the register file's single write port, with WAW kill of stale loads.
module reg_write_arbiter #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic              rs1_pend,
    output logic              rs2_pend,
    output logic              wrt,
    output logic [ADDR_W-1:0] rd,
    output logic [DATA_W-1:0] dataIn
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] fifo_rd   [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [DEPTH-1:0]  fifo_live;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic fifo_empty;
    logic push;
    logic pop;
    logic head_live;
    logic push_killed;

    // Room is judged on registered count only, so a same-cycle pop never frees a slot.
    assign mem_ready   = !rst && (count < CNT_W'(DEPTH));
    assign fifo_empty  = (count == '0);
    assign push        = mem_valid && mem_ready;
    assign pop         = !rst && !alu_valid && !fifo_empty;
    assign head_live   = fifo_live[rd_ptr];
    assign push_killed = alu_valid && (mem_rd == alu_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Live bits also drop on pop so that only queued entries feed the pending flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_live <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push && (wr_ptr == PTR_W'(i))) begin
                    fifo_live[i] <= !push_killed;
                end else if (pop && (rd_ptr == PTR_W'(i))) begin
                    fifo_live[i] <= 1'b0;
                end else if (alu_valid && (fifo_rd[i] == alu_rd)) begin
                    fifo_live[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= mem_rd;
            fifo_data[wr_ptr] <= mem_data;
        end
    end

    // Output stage: ALU first, then FIFO head; a dead head burns one idle slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrt    <= 1'b0;
            rd     <= '0;
            dataIn <= '0;
        end else if (alu_valid) begin
            wrt    <= 1'b1;
            rd     <= alu_rd;
            dataIn <= alu_data;
        end else if (!fifo_empty) begin
            wrt <= head_live;
            if (head_live) begin
                rd     <= fifo_rd[rd_ptr];
                dataIn <= fifo_data[rd_ptr];
            end
        end else begin
            wrt <= 1'b0;
        end
    end

    always_comb begin
        rs1_pend = wrt && (rd == rs1);
        rs2_pend = wrt && (rd == rs2);
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_live[i] && (fifo_rd[i] == rs1)) rs1_pend = 1'b1;
            if (fifo_live[i] && (fifo_rd[i] == rs2)) rs2_pend = 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: ALU path, load path, backpressure,
// WAW kill, same-cycle same-rd, and mid-operation reset.
module tb_reg_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [5:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic [5:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic [5:0]  rs1;
    logic [5:0]  rs2;
    logic        rs1_pend;
    logic        rs2_pend;
    logic        wrt;
    logic [5:0]  rd;
    logic [31:0] dataIn;

    int n_cmp = 0;
    int n_bad = 0;

    reg_write_arbiter #(.DEPTH(4), .ADDR_W(6), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
        .mem_ready(mem_ready),
        .rs1(rs1), .rs2(rs2), .rs1_pend(rs1_pend), .rs2_pend(rs2_pend),
        .wrt(wrt), .rd(rd), .dataIn(dataIn)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
    endtask

    task automatic alu(input logic [5:0] r, input logic [31:0] d);
        alu_valid = 1'b1;
        alu_rd    = r;
        alu_data  = d;
    endtask

    task automatic mem(input logic [5:0] r, input logic [31:0] d);
        mem_valid = 1'b1;
        mem_rd    = r;
        mem_data  = d;
    endtask

    task automatic out(input string tag, input logic w, input logic [5:0] r, input logic [31:0] d);
        chk({tag, ".wrt"}, 32'(wrt), 32'(w));
        chk({tag, ".rd"}, 32'(rd), 32'(r));
        chk({tag, ".data"}, dataIn, d);
    endtask

    initial begin
        rst = 1'b1; idle(); alu_rd = '0; alu_data = '0; mem_rd = '0; mem_data = '0;
        rs1 = 6'd0; rs2 = 6'd0;

        // Reset state
        step(); step();
        out("rst", 1'b0, 6'd0, 32'h0);
        chk("rst.ready", 32'(mem_ready), 32'd0);
        rst = 1'b0; #1;
        chk("post_rst.ready", 32'(mem_ready), 32'd1);

        // ALU only
        alu(6'd5, 32'h11); step();
        out("alu.c2", 1'b1, 6'd5, 32'h11);
        chk("alu.c2.ready", 32'(mem_ready), 32'd1);
        idle(); step();
        chk("alu.c3.wrt", 32'(wrt), 32'd0);
        chk("alu.c3.ready", 32'(mem_ready), 32'd1);

        // Memory only: two-cycle latency, pending through the output stage
        rs1 = 6'd7;
        mem(6'd7, 32'hAA); step(); idle();
        chk("mem.c2.pend", 32'(rs1_pend), 32'd1);
        chk("mem.c2.wrt", 32'(wrt), 32'd0);
        step();
        out("mem.c3", 1'b1, 6'd7, 32'hAA);
        chk("mem.c3.pend", 32'(rs1_pend), 32'd1);
        step();
        chk("mem.c4.pend", 32'(rs1_pend), 32'd0);
        chk("mem.c4.wrt", 32'(wrt), 32'd0);

        // Fill under continuous ALU traffic, then drain in order
        rs2 = 6'd3;
        for (int i = 1; i <= 4; i++) begin
            alu(6'd20, 32'h0);
            mem(6'(i), 32'h1000 + 32'(i));
            chk($sformatf("fill%0d.ready", i), 32'(mem_ready), 32'd1);
            step();
        end
        chk("full.ready", 32'(mem_ready), 32'd0);
        chk("full.pend3", 32'(rs2_pend), 32'd1);
        mem(6'd5, 32'h1005); step();
        chk("full5.ready", 32'(mem_ready), 32'd0);
        chk("full5.wrt_alu", 32'(rd), 32'd20);
        idle();
        for (int i = 1; i <= 4; i++) begin
            step();
            out($sformatf("drain%0d", i), 1'b1, 6'(i), 32'h1000 + 32'(i));
            chk($sformatf("drain%0d.ready", i), 32'(mem_ready), 32'd1);
        end
        step();
        chk("drain.no5", 32'(wrt), 32'd0);

        // WAW kill while the FIFO is starved by ALU writes to rd=3
        rs1 = 6'd9;
        alu(6'd3, 32'h33); mem(6'd9, 32'h100); step();
        out("waw.a", 1'b1, 6'd3, 32'h33);
        chk("waw.a.pend", 32'(rs1_pend), 32'd1);
        mem_valid = 1'b0; alu(6'd9, 32'h200); step();
        out("waw.b", 1'b1, 6'd9, 32'h200);
        alu(6'd3, 32'h34); step();
        out("waw.c", 1'b1, 6'd3, 32'h34);
        chk("waw.c.pend", 32'(rs1_pend), 32'd0);
        idle(); step();
        chk("waw.dead_slot", 32'(wrt), 32'd0);
        step();
        chk("waw.after", 32'(wrt), 32'd0);

        // Same-cycle ALU and load to the same register
        rs1 = 6'd12;
        alu(6'd12, 32'h6); mem(6'd12, 32'h5); step(); idle();
        out("same.c2", 1'b1, 6'd12, 32'h6);
        chk("same.c2.pend", 32'(rs1_pend), 32'd1);
        step();
        out("same.dead", 1'b0, 6'd12, 32'h6);
        chk("same.dead.pend", 32'(rs1_pend), 32'd0);
        step();
        chk("same.after", 32'(wrt), 32'd0);

        // Reset with three queued loads and a load offered in the reset cycle
        rs1 = 6'd21;
        for (int i = 0; i < 3; i++) begin
            alu(6'd30, 32'h30); mem(6'(21 + i), 32'h2100 + 32'(i)); step();
        end
        chk("prerst.pend", 32'(rs1_pend), 32'd1);
        alu_valid = 1'b0; mem(6'd24, 32'h2400); rst = 1'b1; #1;
        chk("midrst.ready", 32'(mem_ready), 32'd0);
        step();
        out("midrst", 1'b0, 6'd0, 32'h0);
        chk("midrst.ready2", 32'(mem_ready), 32'd0);
        rst = 1'b0; idle(); #1;
        chk("midrst.after.ready", 32'(mem_ready), 32'd1);
        chk("midrst.after.pend", 32'(rs1_pend), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("midrst.lost%0d", i), 32'(wrt), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Write-back stage directly upstream of the 64x32 register file.
- Merges two write sources into the register file's single write port (wrt/rd/dataIn):
  - ALU results: single-cycle, always accepted, highest priority.
  - Memory/load results: buffered in a small FIFO, drained on cycles the ALU does not use the port.
- Exports per-operand pending flags so the decode/stall logic can hold instructions whose source registers have an outstanding write.

Parameters:
- DEPTH, 4, memory-write FIFO entries (power of 2, >=2).
- ADDR_W, 6, register address width (64 registers).
- DATA_W, 32, register data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- alu_valid  in  1  ALU write request; always accepted.
- alu_rd  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU write data.
- mem_valid  in  1  memory write request.
- mem_rd  in  ADDR_W  memory destination register.
- mem_data  in  DATA_W  memory write data.
- mem_ready  out  1  FIFO can accept; push = mem_valid && mem_ready.
- rs1  in  ADDR_W  source-1 address to check.
- rs2  in  ADDR_W  source-2 address to check.
- rs1_pend  out  1  outstanding write targets rs1.
- rs2_pend  out  1  outstanding write targets rs2.
- wrt  out  1  register-file write enable (registered).
- rd  out  ADDR_W  register-file write address (registered).
- dataIn  out  DATA_W  register-file write data (registered).

Behaviour:
- Reset (rst=1 at posedge):
  - wrt=0, rd=0, dataIn=0.
  - FIFO emptied; all entry live bits cleared.
  - A mem request presented in that cycle is dropped.
  - mem_ready=0 while rst=1.
- Output stage: wrt/rd/dataIn is one register, loaded every posedge with this priority:
  1. alu_valid=1: load {1, alu_rd, alu_data}.
  2. FIFO non-empty and head live: load {1, head.rd, head.data}; pop.
  3. FIFO non-empty and head killed: load wrt=0; pop. A dead entry costs one cycle.
  4. Otherwise: wrt=0. rd/dataIn hold their previous values.
- Latency:
  - ALU: request in cycle N -> wrt=1 in cycle N+1.
  - Memory: push in cycle N -> earliest wrt=1 in cycle N+2. There is no FIFO bypass.
- FIFO:
  - Circular buffer with per-entry {live, rd, data}.
  - Pointers wrap modulo DEPTH; count range 0..DEPTH.
  - mem_ready = !rst && (count < DEPTH), decoded from registered count.
  - A pop in the same cycle does not create room: no push when full, even if popping.
  - Push and pop in the same cycle: count unchanged.
  - Live entries drain in FIFO order.
- WAW kill:
  - When alu_valid=1, every FIFO entry with rd==alu_rd has live cleared at that posedge.
  - A same-cycle push with mem_rd==alu_rd is enqueued with live=0.
  - The ALU write is always treated as newest.
  - Result: a stale load can never overwrite a newer ALU result.
- Pending flags (combinational from registered state only):
  - rsX_pend=1 if (wrt && rd==rsX) OR any entry with live=1 and rd==rsX.
  - Ignores the current-cycle alu_*/mem_* inputs.
  - The output stage is included because the register file reads before writing on the same edge.
- Starvation: continuous alu_valid starves the FIFO indefinitely. This is permitted; the FIFO fills and mem_ready drops to 0.
- All 64 registers are writable; no address is special-cased.
- Reset mid-operation: pending FIFO writes are lost and no write issues in the reset cycle.

Test Plan:
- Reset, then ALU only:
  - Stimulus: alu {rd=5, data=0x11} in cycle 1.
  - Required: wrt=1, rd=5, dataIn=0x11 in cycle 2; wrt=0 in cycle 3; mem_ready=1 throughout.
- Memory only:
  - Stimulus: push {rd=7, 0xAA} in cycle 1.
  - Required: rs1=7 gives rs1_pend=1 in cycles 2..3; wrt=1, rd=7, dataIn=0xAA in cycle 3; rs1_pend=0 in cycle 4.
- Fill and backpressure:
  - Stimulus: alu_valid=1 continuously; push rd=1..4.
  - Required: mem_ready=0 after the 4th push; a 5th mem_valid is not accepted.
  - Then drop alu_valid: writes rd=1,2,3,4 appear on consecutive cycles in order; mem_ready returns to 1 after the first pop.
- WAW kill:
  - Stimulus: push {rd=9, 0x100}, then alu {rd=9, 0x200} the next cycle, while the FIFO is starved by ALU traffic to rd=3.
  - Required: the only write to rd=9 carries 0x200; the dead entry yields a wrt=0 slot.
- Simultaneous same-rd:
  - Stimulus: mem_valid {rd=12, 0x5} and alu_valid {rd=12, 0x6} in the same cycle.
  - Required: rd=12 is written 0x6 once; the mem entry drains with wrt=0.
- Reset mid-operation:
  - Stimulus: 3 entries queued; rst=1 for one cycle.
  - Required: wrt=0, rd=0, dataIn=0 and mem_ready=0 during reset; no queued writes appear afterwards; mem_ready=1 the next cycle.
